mem_port_arbiter: RTL and testbench

- Shares one single-ported unified memory between instruction fetch and the decoder-driven load/store path.
- Arbitrates between the two requesters and sequences each bus transaction through a small FSM.
- Generates byte strobes and write-lane alignment from the decoded LD/ST width.
- Extracts and sign- or zero-extends load data. Sits between fetch/execute stages and the memory model/bus.

---
 rtl/mem_port_arbiter.sv | 175 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and load/store.
// Data requests win unless fetch has waited through MAX_D_STREAK data grants.
module mem_port_arbiter #(
    parameter int MAX_D_STREAK = 4,
    parameter int LDST_WIDTH_W = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_req,
    input  logic [31:0]             i_addr,
    output logic [31:0]             i_rdata,
    output logic                    i_done,
    input  logic                    d_ren,
    input  logic                    d_wen,
    input  logic [31:0]             d_addr,
    input  logic [31:0]             d_wdata,
    input  logic [LDST_WIDTH_W-1:0] d_width,
    input  logic                    d_unsigned,
    output logic [31:0]             d_rdata,
    output logic                    d_done,
    output logic                    d_err,
    output logic                    m_req,
    output logic                    m_wen,
    output logic [31:0]             m_addr,
    output logic [31:0]             m_wdata,
    output logic [3:0]              m_strb,
    input  logic [31:0]             m_rdata,
    input  logic                    m_ack
);
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

    localparam logic [LDST_WIDTH_W-1:0] W_BYTE = LDST_WIDTH_W'(0);
    localparam logic [LDST_WIDTH_W-1:0] W_HALF = LDST_WIDTH_W'(1);
    localparam logic [LDST_WIDTH_W-1:0] W_WORD = LDST_WIDTH_W'(2);

    state_t                  state;
    logic [3:0]              streak;
    logic [1:0]              lane_p0;
    logic [LDST_WIDTH_W-1:0] width_p0;
    logic                    unsigned_p0;
    logic                    d_any;
    logic                    d_illegal;
    logic                    i_win;

    function automatic logic access_illegal(input logic ren, input logic wen,
                                            input logic [LDST_WIDTH_W-1:0] width,
                                            input logic [1:0] lo);
        logic bad;
        bad = ren && wen;
        case (width)
            W_BYTE:  bad = bad;
            W_HALF:  bad = bad | lo[0];
            W_WORD:  bad = bad | (lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [LDST_WIDTH_W-1:0] width,
                                               input logic [31:0] wdata);
        case (width)
            W_BYTE:  return {4{wdata[7:0]}};
            W_HALF:  return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    function automatic logic [3:0] lane_strb(input logic [LDST_WIDTH_W-1:0] width,
                                             input logic [1:0] lo);
        case (width)
            W_BYTE:  return 4'b0001 << lo;
            W_HALF:  return lo[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] extend_load(input logic [31:0] word,
                                                input logic [LDST_WIDTH_W-1:0] width,
                                                input logic [1:0] lo, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lo, 3'b000} +: 8];
        h = lo[1] ? word[31:16] : word[15:0];
        case (width)
            W_BYTE:  return uns ? {24'b0, b} : {{24{b[7]}}, b};
            W_HALF:  return uns ? {16'b0, h} : {{16{h[15]}}, h};
            default: return word;
        endcase
    endfunction

    assign d_any     = d_ren | d_wen;
    assign d_illegal = access_illegal(d_ren, d_wen, d_width, d_addr[1:0]);
    assign i_win     = i_req && (!d_any || streak == 4'(MAX_D_STREAK));

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            streak      <= 4'd0;
            i_rdata     <= 32'd0;
            i_done      <= 1'b0;
            d_rdata     <= 32'd0;
            d_done      <= 1'b0;
            d_err       <= 1'b0;
            m_req       <= 1'b0;
            m_wen       <= 1'b0;
            m_addr      <= 32'd0;
            m_wdata     <= 32'd0;
            m_strb      <= 4'd0;
            lane_p0     <= 2'd0;
            width_p0    <= '0;
            unsigned_p0 <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_win) begin
                        state   <= BUSY_I;
                        streak  <= 4'd0;
                        m_req   <= 1'b1;
                        m_wen   <= 1'b0;
                        m_addr  <= i_addr & 32'hFFFF_FFFC;
                        m_wdata <= 32'd0;
                        m_strb  <= 4'b1111;
                    end else if (d_any) begin
                        // Streak only grows while fetch is actually waiting.
                        streak <= i_req ? streak + 4'd1 : 4'd0;
                        if (d_illegal) begin
                            state   <= RESP;
                            d_done  <= 1'b1;
                            d_err   <= 1'b1;
                            d_rdata <= 32'd0;
                        end else begin
                            state       <= BUSY_D;
                            m_req       <= 1'b1;
                            m_wen       <= d_wen;
                            m_addr      <= d_addr & 32'hFFFF_FFFC;
                            m_wdata     <= d_wen ? lane_wdata(d_width, d_wdata) : 32'd0;
                            m_strb      <= d_wen ? lane_strb(d_width, d_addr[1:0]) : 4'b1111;
                            lane_p0     <= d_addr[1:0];
                            width_p0    <= d_width;
                            unsigned_p0 <= d_unsigned;
                        end
                    end
                end
                BUSY_I: begin
                    if (m_ack) begin
                        state   <= RESP;
                        m_req   <= 1'b0;
                        m_strb  <= 4'd0;
                        i_rdata <= m_rdata;
                        i_done  <= 1'b1;
                    end
                end
                BUSY_D: begin
                    if (m_ack) begin
                        state   <= RESP;
                        m_req   <= 1'b0;
                        m_wen   <= 1'b0;
                        m_strb  <= 4'd0;
                        d_rdata <= m_wen ? 32'd0
                                         : extend_load(m_rdata, width_p0, lane_p0, unsigned_p0);
                        d_done  <= 1'b1;
                        d_err   <= 1'b0;
                    end
                end
                RESP: begin
                    state  <= IDLE;
                    i_done <= 1'b0;
                    d_done <= 1'b0;
                    d_err  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized transactions
// checked against a transaction-level reference model.
module tb_mem_port_arbiter;
    localparam int MAX_D_STREAK = 4;
    localparam int LDST_WIDTH_W = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req, d_ren, d_wen, d_unsigned, m_ack;
    logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
    logic [1:0]  d_width;
    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
    logic        i_done, d_done, d_err, m_req, m_wen;
    logic [3:0]  m_strb;

    int n_chk = 0;
    int n_fail = 0;
    int m_streak = 0;
    logic [31:0] obs_addr, obs_wdata, obs_rdata;
    logic [3:0]  obs_strb;
    logic        obs_wen, obs_err, obs_mreq, obs_grant_d;

    mem_port_arbiter #(.MAX_D_STREAK(MAX_D_STREAK), .LDST_WIDTH_W(LDST_WIDTH_W)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
        .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_width(d_width), .d_unsigned(d_unsigned), .d_rdata(d_rdata),
        .d_done(d_done), .d_err(d_err),
        .m_req(m_req), .m_wen(m_wen), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_strb(m_strb), .m_rdata(m_rdata), .m_ack(m_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        i_req = 0; i_addr = 0; d_ren = 0; d_wen = 0; d_addr = 0; d_wdata = 0;
        d_width = 0; d_unsigned = 0; m_rdata = 0; m_ack = 0;
        repeat (2) @(negedge clk);
        check("rst_ctrl", 32'({i_done, d_done, d_err, m_req, m_wen, m_strb}), 32'd0);
        check("rst_data", i_rdata | d_rdata | m_addr | m_wdata, 32'd0);
        rst = 1'b0;
        m_streak = 0;
    endtask

    // Called at the falling edge of the cycle in which the DUT sits in IDLE and
    // samples the current requests; returns at the falling edge of the done cycle.
    task automatic do_txn(input int lat, input logic [31:0] word);
        logic        take_i, illegal, is_load;
        int          size, lo;
        logic [31:0] e_addr, e_wdata, e_rdata, mask;
        logic [3:0]  e_strb;
        take_i = i_req && (!(d_ren || d_wen) || m_streak == MAX_D_STREAK);
        if (take_i) m_streak = 0;
        else m_streak = i_req ? m_streak + 1 : 0;
        lo = int'(d_addr[1:0]);
        case (d_width)
            2'd0: size = 1;
            2'd1: size = 2;
            2'd2: size = 4;
            default: size = 0;
        endcase
        illegal = (d_ren && d_wen) || size == 0;
        if (!illegal && (lo % size) != 0) illegal = 1'b1;
        is_load = d_ren && !d_wen;
        e_wdata = 32'd0;
        e_rdata = word;
        e_strb  = 4'hF;
        if (take_i) begin
            e_addr  = i_addr & ~32'h3;
            illegal = 1'b0;
        end else begin
            e_addr = d_addr & ~32'h3;
            if (!illegal) begin
                if (d_wen) begin
                    e_strb = 4'(((1 << size) - 1) << lo);
                    for (int b = 0; b < 4; b++) e_wdata[8*b +: 8] = d_wdata[8*(b % size) +: 8];
                end
                if (size != 4) begin
                    mask    = (32'h1 << (8*size)) - 32'h1;
                    e_rdata = (word >> (8*lo)) & mask;
                    if (!d_unsigned && e_rdata[8*size-1]) e_rdata = e_rdata | ~mask;
                end
            end
        end

        @(negedge clk);
        obs_mreq = m_req;
        if (illegal) begin
            check("err_ctrl", 32'({d_done, d_err, i_done, m_req}), 32'(4'b1100));
            check("err_rdata", d_rdata, 32'd0);
            obs_err = d_err; obs_grant_d = d_done; obs_rdata = d_rdata;
            d_ren = 0; d_wen = 0;
            return;
        end
        obs_addr = m_addr; obs_strb = m_strb; obs_wdata = m_wdata; obs_wen = m_wen;
        for (int c = 1; c <= lat + 1; c++) begin
            check("busy_ctrl", 32'({m_req, m_wen, i_done, d_done}),
                  32'({1'b1, (!take_i && d_wen), 2'b00}));
            check("busy_addr", m_addr, e_addr);
            check("busy_strb", 32'(m_strb), 32'(e_strb));
            if (!take_i && d_wen) check("busy_wdata", m_wdata, e_wdata);
            m_ack   = (c == lat + 1);
            m_rdata = m_ack ? word : $urandom;
            @(negedge clk);
        end
        m_ack   = 1'b0;
        m_rdata = $urandom;
        obs_err = d_err; obs_grant_d = d_done;
        obs_rdata = take_i ? i_rdata : d_rdata;
        check("done_ctrl", 32'({i_done, d_done, d_err, m_req}), 32'({take_i, !take_i, 2'b00}));
        if (take_i) check("fetch_rdata", i_rdata, e_rdata);
        else if (is_load) check("load_rdata", d_rdata, e_rdata);
        if (take_i) i_req = 1'b0;
        else begin d_ren = 1'b0; d_wen = 1'b0; end
    endtask

    initial begin
        logic [9:0]  order;
        logic [31:0] tmp;
        int          op;

        apply_reset();

        i_req = 1; i_addr = 32'h100;
        do_txn(1, 32'h00500093);
        check("plan_fetch_addr", obs_addr, 32'h100);
        check("plan_fetch_rdata", obs_rdata, 32'h00500093);
        check("plan_fetch_grant", 32'(obs_grant_d), 32'd0);
        @(negedge clk);

        d_ren = 1; d_width = 2'd0; d_unsigned = 0; d_addr = 32'h203;
        do_txn(2, 32'h80FFFFFF);
        check("plan_lb_addr", obs_addr, 32'h200);
        check("plan_lb_strb", 32'(obs_strb), 32'hF);
        check("plan_lb_rdata", obs_rdata, 32'hFFFFFF80);
        @(negedge clk);
        d_ren = 1; d_unsigned = 1;
        do_txn(0, 32'h80FFFFFF);
        check("plan_lbu_rdata", obs_rdata, 32'h00000080);
        @(negedge clk);

        d_wen = 1; d_width = 2'd1; d_addr = 32'h402; d_wdata = 32'h1234ABCD;
        do_txn(1, $urandom);
        check("plan_sh_wen", 32'(obs_wen), 32'd1);
        check("plan_sh_wdata", obs_wdata, 32'hABCDABCD);
        check("plan_sh_strb", 32'(obs_strb), 32'hC);
        check("plan_sh_addr", obs_addr, 32'h400);
        @(negedge clk);

        for (int k = 0; k < 3; k++) begin
            d_ren   = 1;
            d_wen   = (k == 2);
            d_width = (k == 1) ? 2'd3 : 2'd2;
            d_addr  = (k == 0) ? 32'h101 : 32'h200;
            do_txn(0, 32'd0);
            check("plan_illegal", 32'({obs_err, obs_mreq}), 32'(2'b10));
            @(negedge clk);
            check("plan_illegal_idle", 32'({m_req, d_done}), 32'd0);
        end

        apply_reset();
        i_req = 1; i_addr = 32'h40; d_ren = 1; d_wen = 0; d_width = 2'd2; d_addr = 32'h80;
        for (int k = 0; k < 10; k++) begin
            do_txn(0, $urandom);
            order[k] = obs_grant_d;
            @(negedge clk);
            i_req = 1; d_ren = 1;
        end
        check("starve_order", 32'(order), 32'(10'b0111101111));

        apply_reset();
        d_ren = 1; d_width = 2'd2; d_addr = 32'h200;
        @(negedge clk);
        check("rst_busy_mreq", 32'(m_req), 32'd1);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        check("rst_drop_mreq", 32'(m_req), 32'd0);
        rst = 0; d_ren = 0; m_ack = 1; m_rdata = 32'hDEADBEEF;
        @(negedge clk);
        m_ack = 0;
        check("late_ack_1", 32'({i_done, d_done, m_req}), 32'd0);
        @(negedge clk);
        check("late_ack_2", 32'({i_done, d_done, m_req}), 32'd0);
        m_streak = 0;
        i_req = 1; i_addr = 32'h300;
        do_txn(1, 32'h12345678);
        check("post_rst_fetch", obs_rdata, 32'h12345678);
        @(negedge clk);

        for (int n = 0; n < 80; n++) begin
            if (!i_req && $urandom_range(0, 1) == 1) begin
                tmp = $urandom; i_addr = tmp & ~32'h3; i_req = 1;
            end
            if (!d_ren && !d_wen && $urandom_range(0, 1) == 1) begin
                op      = int'($urandom_range(0, 7));
                d_ren   = (op < 4) || (op == 7);
                d_wen   = (op >= 4);
                d_width = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
                d_addr  = $urandom;
                if ($urandom_range(0, 2) != 0) begin
                    if (d_width == 2'd1) d_addr[0] = 1'b0;
                    else if (d_width == 2'd2) d_addr[1:0] = 2'b00;
                end
                d_wdata    = $urandom;
                d_unsigned = 1'($urandom_range(0, 1));
            end
            if (!i_req && !d_ren && !d_wen) begin
                tmp = $urandom; i_addr = tmp & ~32'h3; i_req = 1;
            end
            do_txn(int'($urandom_range(0, 3)), $urandom);
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
